// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: FSM encoding, default sizes and
// the two-way round-robin pick rule.
package shift_arbiter_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_CNT_W   = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Pointer names the preferred requester; a lone request wins regardless.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        logic idx;
        if (req == 2'b11) begin
            idx = ptr;
        end else begin
            idx = req[1];
        end
        return idx;
    endfunction

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant from the current pointer,
// pointer advanced by the owner on completion.
module shift_arbiter_rr_arb2
    import shift_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       next_ptr,
    output logic       grant_valid_c,
    output logic       grant_idx_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (update) begin
            ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_valid_c = |req;
    assign grant_idx_c   = rr_pick(req, ptr_q);

endmodule

// File: rtl/shift_arbiter.sv
// Shares one iterative shifter between two requesters: round-robin grant,
// operand latch, start pulse, bounded wait for ready, result return.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] value0,
    input  logic [WIDTH-1:0] value1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [CNT_W-1:0] times0,
    input  logic [CNT_W-1:0] times1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             sh_start,
    output logic [WIDTH-1:0] sh_value,
    output logic             sh_dir,
    output logic [CNT_W-1:0] sh_times,
    input  logic             sh_ready,
    input  logic [WIDTH-1:0] sh_result,
    output logic             busy,
    output logic             owner,
    output logic             timeout_err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    state_e             state_q,       state_d;
    logic               sh_start_q,    sh_start_d;
    logic [WIDTH-1:0]   sh_value_q,    sh_value_d;
    logic               sh_dir_q,      sh_dir_d;
    logic [CNT_W-1:0]   sh_times_q,    sh_times_d;
    logic               done0_q,       done0_d;
    logic               done1_q,       done1_d;
    logic [WIDTH-1:0]   result0_q,     result0_d;
    logic [WIDTH-1:0]   result1_q,     result1_d;
    logic               busy_q,        busy_d;
    logic               owner_q,       owner_d;
    logic               timeout_err_q, timeout_err_d;
    logic [TIMER_W-1:0] timer_q,       timer_d;

    logic grant_valid_c;
    logic grant_idx_c;

    shift_arbiter_rr_arb2 u_rr (
        .clk          (clk),
        .reset        (reset),
        .req          ({req1, req0}),
        .update       (state_q == ST_RESP),
        .next_ptr     (~owner_q),
        .grant_valid_c(grant_valid_c),
        .grant_idx_c  (grant_idx_c)
    );

    always_comb begin
        state_d       = state_q;
        sh_start_d    = 1'b0;
        sh_value_d    = sh_value_q;
        sh_dir_d      = sh_dir_q;
        sh_times_d    = sh_times_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        result0_d     = result0_q;
        result1_d     = result1_q;
        owner_d       = owner_q;
        timeout_err_d = timeout_err_q;
        timer_d       = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    owner_d    = grant_idx_c;
                    sh_value_d = grant_idx_c ? value1 : value0;
                    sh_dir_d   = grant_idx_c ? dir1   : dir0;
                    sh_times_d = grant_idx_c ? times1 : times0;
                    sh_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            // Ready may still be high from the previous operation here.
            ST_GUARD: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sh_ready) begin
                    if (owner_q) begin
                        result1_d = sh_result;
                    end else begin
                        result0_d = sh_result;
                    end
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = ST_RESP;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    if (owner_q) begin
                        result1_d = '0;
                    end else begin
                        result0_d = '0;
                    end
                    timeout_err_d = 1'b1;
                    done0_d       = ~owner_q;
                    done1_d       = owner_q;
                    state_d       = ST_RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_RESP: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sh_start_q    <= 1'b0;
            sh_value_q    <= '0;
            sh_dir_q      <= 1'b0;
            sh_times_q    <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            result0_q     <= '0;
            result1_q     <= '0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            sh_start_q    <= sh_start_d;
            sh_value_q    <= sh_value_d;
            sh_dir_q      <= sh_dir_d;
            sh_times_q    <= sh_times_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            result0_q     <= result0_d;
            result1_q     <= result1_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign sh_start    = sh_start_q;
    assign sh_value    = sh_value_q;
    assign sh_dir      = sh_dir_q;
    assign sh_times    = sh_times_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign result0     = result0_q;
    assign result1     = result1_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: behavioural shifter plus a transaction-level model
// of grant order, result, latency and the sticky timeout flag.
module tb_shift_arbiter;

    localparam int unsigned W       = 16;
    localparam int unsigned CW      = 4;
    localparam int unsigned TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [W-1:0]  value0, value1;
    logic          dir0, dir1;
    logic [CW-1:0] times0, times1;
    logic          done0, done1;
    logic [W-1:0]  result0, result1;
    logic          sh_start;
    logic [W-1:0]  sh_value;
    logic          sh_dir;
    logic [CW-1:0] sh_times;
    logic          sh_ready;
    logic [W-1:0]  sh_result;
    logic          busy, owner, timeout_err;

    int   n_pass  = 0;
    int   n_total = 0;
    int   delay   = 1;
    bit   lag_clear = 1'b0;
    logic ref_ptr  = 1'b0;
    logic ref_terr = 1'b0;

    shift_arbiter #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .value0(value0), .value1(value1),
        .dir0(dir0), .dir1(dir1),
        .times0(times0), .times1(times1),
        .done0(done0), .done1(done1),
        .result0(result0), .result1(result1),
        .sh_start(sh_start), .sh_value(sh_value), .sh_dir(sh_dir), .sh_times(sh_times),
        .sh_ready(sh_ready), .sh_result(sh_result),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic d,
                                               input logic [CW-1:0] t);
        return d ? (v >> t) : (v << t);
    endfunction

    // Shifter model: ready rises 'delay' cycles after start (0 = never),
    // stays high until the next start; lag_clear keeps stale ready one cycle longer.
    int           cnt;
    logic [W-1:0] pend;
    bit           lag;
    always @(posedge clk) begin
        if (reset) begin
            sh_ready  <= 1'b0;
            sh_result <= '0;
            cnt       <= 0;
            lag       <= 1'b0;
        end else if (sh_start) begin
            pend <= ref_shift(sh_value, sh_dir, sh_times);
            cnt  <= delay;
            if (lag_clear) lag <= 1'b1;
            else sh_ready <= 1'b0;
        end else begin
            if (lag) begin
                sh_ready <= 1'b0;
                lag      <= 1'b0;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    sh_ready  <= 1'b1;
                    sh_result <= pend;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(output bit ok, output int lat, output logic who);
        ok = 1'b0; lat = 0; who = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done0 || done1) begin
                ok = 1'b1; lat = i; who = done1;
                break;
            end
        end
    endtask

    // One transaction from an idle arbiter: d = shifter delay (0 = never ready).
    task automatic run_op(input string tag, input logic r0, input logic r1, input int d,
                          input bit hold, input bit mutate);
        logic          exp_who, who;
        logic [W-1:0]  op_val, exp_res, got_res;
        logic          op_dir;
        logic [CW-1:0] op_times;
        int            waited, lat, exp_lat;
        bit            ok;
        for (int i = 0; i < 20 && busy; i++) tick();
        exp_who  = (r0 && r1) ? ref_ptr : r1;
        op_val   = exp_who ? value1 : value0;
        op_dir   = exp_who ? dir1   : dir0;
        op_times = exp_who ? times1 : times0;
        exp_res  = (d == 0) ? '0 : ref_shift(op_val, op_dir, op_times);
        exp_lat  = (d == 0) ? int'(TIMEOUT) + 2 : d + 2;
        delay = d;
        req0  = r0;
        req1  = r1;
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sh_start) begin
                waited = i;
                break;
            end
        end
        check({tag, "/start_lat"}, 32'(waited), 32'd1);
        check({tag, "/owner"},     32'(owner), 32'(exp_who));
        check({tag, "/sh_value"},  32'(sh_value), 32'(op_val));
        check({tag, "/sh_dir"},    32'(sh_dir), 32'(op_dir));
        check({tag, "/sh_times"},  32'(sh_times), 32'(op_times));
        check({tag, "/busy"},      32'(busy), 32'd1);
        if (mutate) begin
            tick();
            tick();
            if (exp_who) value1 = ~value1;
            else value0 = ~value0;
        end
        wait_done(ok, lat, who);
        if (mutate) lat += 2;
        got_res = exp_who ? result1 : result0;
        if (d == 0) ref_terr = 1'b1;
        check({tag, "/done_seen"}, 32'(ok), 32'd1);
        check({tag, "/done_who"},  32'(who), 32'(exp_who));
        check({tag, "/done_both"}, 32'(done0 & done1), 32'd0);
        check({tag, "/done_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "/result"},    32'(got_res), 32'(exp_res));
        check({tag, "/terr"},      32'(timeout_err), 32'(ref_terr));
        ref_ptr = ~exp_who;
        if (!hold) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        reset    = 1'b0;
        ref_ptr  = 1'b0;
        ref_terr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        value0 = '0; value1 = '0; dir0 = 1'b0; dir1 = 1'b0; times0 = '0; times1 = '0;
        tick(); tick(); tick();
        check("rst/busy",    32'(busy), 32'd0);
        check("rst/owner",   32'(owner), 32'd0);
        check("rst/terr",    32'(timeout_err), 32'd0);
        check("rst/start",   32'(sh_start), 32'd0);
        check("rst/done",    32'({done1, done0}), 32'd0);
        check("rst/result0", 32'(result0), 32'd0);
        check("rst/result1", 32'(result1), 32'd0);
        check("rst/sh_value", 32'(sh_value), 32'd0);
        reset = 1'b0;

        // Single requester, right shift
        value0 = 16'h00F0; dir0 = 1'b1; times0 = 4'd4;
        run_op("t1", 1'b1, 1'b0, 3, 1'b0, 1'b0);
        check("t1/result0_const", 32'(result0), 32'h000F);
        check("t1/done1_never", 32'(done1), 32'd0);

        // Both held: alternate 0,1,0
        do_reset();
        value0 = 16'($urandom); dir0 = 1'($urandom); times0 = 4'($urandom);
        value1 = 16'h0001; dir1 = 1'b0; times1 = 4'd3;
        run_op("t2a", 1'b1, 1'b1, 2, 1'b1, 1'b0);
        check("t2a/first_owner", 32'(owner), 32'd0);
        run_op("t2b", 1'b1, 1'b1, 4, 1'b1, 1'b0);
        check("t2b/result1_const", 32'(result1), 32'h0008);
        run_op("t2c", 1'b1, 1'b1, 1, 1'b0, 1'b0);
        check("t2c/third_owner", 32'(owner), 32'd0);

        // Stale ready from the previous op lingers through GUARD
        lag_clear = 1'b1;
        value0 = 16'($urandom); dir0 = 1'b0; times0 = 4'd5;
        run_op("t3", 1'b1, 1'b0, 6, 1'b0, 1'b0);
        lag_clear = 1'b0;

        // Shifter never answers, then a normal op afterwards
        value0 = 16'($urandom);
        run_op("t4a", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        value1 = 16'($urandom); dir1 = 1'b1; times1 = 4'd2;
        run_op("t4b", 1'b0, 1'b1, 4, 1'b0, 1'b0);

        // Reset while waiting on the shifter
        value1 = 16'($urandom);
        delay = 20;
        req1 = 1'b1;
        for (int i = 0; i < 20 && !sh_start; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        req1  = 1'b0;
        tick();
        ref_ptr = 1'b0; ref_terr = 1'b0;
        check("t5/busy",  32'(busy), 32'd0);
        check("t5/owner", 32'(owner), 32'd0);
        check("t5/terr",  32'(timeout_err), 32'(ref_terr));
        check("t5/start", 32'(sh_start), 32'd0);
        check("t5/done",  32'({done1, done0}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("t5/no_done_after", 32'({done1, done0, busy}), 32'd0);
        end
        value1 = 16'($urandom); dir1 = 1'b0; times1 = 4'($urandom);
        run_op("t5b", 1'b0, 1'b1, 5, 1'b0, 1'b0);

        // Operand changes after grant have no effect
        value0 = 16'hA5C3; dir0 = 1'b1; times0 = 4'd3;
        run_op("t6", 1'b1, 1'b0, 8, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            int   pat;
            value0 = 16'($urandom); dir0 = 1'($urandom); times0 = 4'($urandom);
            value1 = 16'($urandom); dir1 = 1'($urandom); times1 = 4'($urandom);
            lag_clear = 1'($urandom);
            pat = int'($urandom_range(1, 3));
            run_op("rnd", pat[0], pat[1], int'($urandom_range(1, 12)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
